axi_burst_reader: RTL and testbench

AXI4 read master that fetches a block of 32-bit words from an AXI slave (boot ROM, SDRAM controller) and streams them out on a valid/ready port. It splits a request into bursts of at most BURST_LEN beats, never crossing a 4 KB boundary. It counts beats itself and does not depend on rlast, because the slaves it talks to do not drive it. It sits between the system AXI fabric and consumers such as the boot loader and the framebuffer prefetcher.

---
 rtl/axi_burst_reader_if.sv | 23 ++
 rtl/axi_burst_reader.sv | 113 +++++++++++
 tb/tb_axi_burst_reader.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_burst_reader_if.sv
// AXI4 read/write signal bundle shared by the burst reader and its slave.
interface axi4_interface;
  logic [31:0] m_aradr;
  logic [7:0]  m_arlen;
  logic        m_arvalid;
  logic        m_rready;
  logic        m_awvalid;
  logic        m_wvalid;
  logic        m_bready;
  logic        s_arready;
  logic        s_rvalid;
  logic [31:0] s_rdata;

  modport master (
    output m_aradr, m_arlen, m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready,
    input  s_arready, s_rvalid, s_rdata
  );

  modport slave (
    input  m_aradr, m_arlen, m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready,
    output s_arready, s_rvalid, s_rdata
  );
endinterface

// File: rtl/axi_burst_reader.sv
// AXI4 read master: fetches a block of words in page-bounded bursts and
// streams them out unbuffered on a valid/ready port; beats are counted locally.
module axi_burst_reader #(
  parameter int unsigned BURST_LEN = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] start_addr,
  input  logic [15:0] word_count,
  output logic        busy,
  output logic        done,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  axi4_interface.master axi_bus
);

  localparam int unsigned ADDR_W     = 30;
  localparam int unsigned CNT_W      = 16;
  localparam int unsigned BEAT_W     = 5;
  localparam int unsigned LEN_W      = 11;
  localparam int unsigned PAGE_WORDS = 1024;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, FINISH} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   word_addr_q, word_addr_d;
  logic [CNT_W-1:0]    remaining_q, remaining_d;
  logic [BEAT_W-1:0]   beats_q, beats_d;

  logic [LEN_W-1:0]    rem_clip;
  logic [LEN_W-1:0]    page_left;
  logic [LEN_W-1:0]    len;
  logic                beat;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^start_addr[1:0];

  // Burst length: bounded by what is left, BURST_LEN, and the 4 KB page end.
  always_comb begin
    rem_clip  = (remaining_q > CNT_W'(BURST_LEN)) ? LEN_W'(BURST_LEN) : LEN_W'(remaining_q);
    page_left = LEN_W'(PAGE_WORDS) - {1'b0, word_addr_q[9:0]};
    len       = (rem_clip < page_left) ? rem_clip : page_left;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      word_addr_q <= '0;
      remaining_q <= '0;
      beats_q     <= '0;
    end else begin
      state_q     <= state_d;
      word_addr_q <= word_addr_d;
      remaining_q <= remaining_d;
      beats_q     <= beats_d;
    end
  end

  assign beat = (state_q == DATA) && axi_bus.s_rvalid && out_ready;

  always_comb begin
    state_d     = state_q;
    word_addr_d = word_addr_q;
    remaining_d = remaining_q;
    beats_d     = beats_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          word_addr_d = start_addr[31:2];
          remaining_d = word_count;
          state_d     = (word_count != '0) ? ADDR : FINISH;
        end
      end
      ADDR: begin
        if (axi_bus.s_arready) begin
          beats_d     = BEAT_W'(len);
          word_addr_d = word_addr_q + ADDR_W'(len);
          remaining_d = remaining_q - CNT_W'(len);
          state_d     = DATA;
        end
      end
      DATA: begin
        if (beat) begin
          beats_d = beats_q - BEAT_W'(1);
          if (beats_q == BEAT_W'(1)) begin
            state_d = (remaining_q != '0) ? ADDR : FINISH;
          end
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status and AXI controls decode straight from the state register.
  assign busy      = (state_q == ADDR) || (state_q == DATA);
  assign done      = (state_q == FINISH);
  assign out_valid = (state_q == DATA) && axi_bus.s_rvalid;
  assign out_data  = axi_bus.s_rdata;

  assign axi_bus.m_arvalid = (state_q == ADDR);
  assign axi_bus.m_aradr   = {word_addr_q, 2'b00};
  assign axi_bus.m_arlen   = 8'(len - LEN_W'(1));
  assign axi_bus.m_rready  = (state_q == DATA) && out_ready;

  // Write channel is never used.
  assign axi_bus.m_awvalid = 1'b0;
  assign axi_bus.m_wvalid  = 1'b0;
  assign axi_bus.m_bready  = 1'b1;

endmodule

// File: tb/tb_axi_burst_reader.sv
// Directed bench for axi_burst_reader with a ROM slave returning word index as data.
module tb_axi_burst_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] start_addr;
  logic [15:0] word_count;
  logic        busy;
  logic        done;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready = 1'b1;

  axi4_interface axi_bus();

  axi_burst_reader #(.BURST_LEN(8)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .word_count(word_count), .busy(busy), .done(done), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .axi_bus(axi_bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Consumer ready: constant high or random 50%.
  bit rand_ready = 1'b0;
  always @(posedge clk) begin
    #1;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // ROM slave: one outstanding burst, optional arready stall.
  int          stall_cfg = 0;
  int          stall_gen = 0;
  int          stall_seen = 0;
  int          stall_left = 0;
  logic        ar_hs_s = 1'b0;
  logic        r_hs_s = 1'b0;
  logic        arv_s = 1'b0;
  logic [31:0] ar_addr_s = '0;
  logic [7:0]  ar_len_s = '0;
  logic [29:0] sl_addr = '0;
  int          sl_left = 0;

  initial begin
    axi_bus.s_arready = 1'b1;
    axi_bus.s_rvalid  = 1'b0;
    axi_bus.s_rdata   = '0;
  end

  always @(negedge clk) begin
    ar_hs_s   = axi_bus.m_arvalid && axi_bus.s_arready;
    r_hs_s    = axi_bus.s_rvalid && axi_bus.m_rready;
    arv_s     = axi_bus.m_arvalid;
    ar_addr_s = axi_bus.m_aradr;
    ar_len_s  = axi_bus.m_arlen;
  end

  always @(posedge clk) begin
    #1;
    if (reset) begin
      sl_left = 0;
    end else begin
      if (r_hs_s) begin
        sl_addr = sl_addr + 30'd1;
        sl_left = sl_left - 1;
      end
      if (ar_hs_s) begin
        sl_addr = ar_addr_s[31:2];
        sl_left = int'(ar_len_s) + 1;
      end
      if (arv_s && !ar_hs_s && stall_left > 0) stall_left = stall_left - 1;
    end
    if (stall_gen != stall_seen) begin
      stall_left = stall_cfg;
      stall_seen = stall_gen;
    end
    axi_bus.s_arready = (stall_left == 0);
    axi_bus.s_rvalid  = (sl_left > 0);
    axi_bus.s_rdata   = {2'b00, sl_addr};
  end

  // Monitor: records handshakes, words, and protocol violations.
  logic [31:0] word_q[$];
  logic [31:0] ar_addr_q[$];
  logic [7:0]  ar_len_q[$];
  int          ar_cyc_q[$];
  int          accept_q[$];
  int          done_q[$];
  int          last_beat_cyc = 0;
  int          rr_viol = 0;
  int          ar_viol = 0;
  int          ar_wait = 0;
  logic        prev_wait = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [7:0]  prev_len = '0;
  int          clr_gen = 0;
  int          clr_seen = 0;

  always @(negedge clk) begin
    if (clr_gen != clr_seen) begin
      word_q.delete(); ar_addr_q.delete(); ar_len_q.delete(); ar_cyc_q.delete();
      accept_q.delete(); done_q.delete();
      rr_viol = 0; ar_viol = 0; ar_wait = 0; prev_wait = 1'b0; last_beat_cyc = 0;
      clr_seen = clr_gen;
    end
    if (!reset) begin
      if (start && !busy && !done) accept_q.push_back(cyc);
      if (axi_bus.m_arvalid && axi_bus.s_arready) begin
        ar_addr_q.push_back(axi_bus.m_aradr);
        ar_len_q.push_back(axi_bus.m_arlen);
        ar_cyc_q.push_back(cyc);
      end
      if (out_valid && out_ready) begin
        word_q.push_back(out_data);
        last_beat_cyc = cyc;
      end
      if (done) done_q.push_back(cyc);
      if (busy && !axi_bus.m_arvalid && (axi_bus.m_rready !== out_ready)) rr_viol++;
      if (prev_wait && (!axi_bus.m_arvalid || axi_bus.m_aradr !== prev_addr ||
                        axi_bus.m_arlen !== prev_len)) ar_viol++;
      prev_wait = axi_bus.m_arvalid && !axi_bus.s_arready;
      prev_addr = axi_bus.m_aradr;
      prev_len  = axi_bus.m_arlen;
      if (prev_wait) ar_wait++;
    end
  end

  // Called aligned one step after a rising edge; leaves the same alignment.
  task automatic clear_mon();
    clr_gen++;
    @(posedge clk); #1;
  endtask

  task automatic issue_start(input logic [31:0] a, input logic [15:0] n);
    start = 1'b1; start_addr = a; word_count = n;
    @(posedge clk); #1;
    start = 1'b0; start_addr = 32'hDEAD_BEEF; word_count = 16'hFFFF;
  endtask

  task automatic wait_done(input int max, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (done) begin
        timed_out = 1'b0;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (axi_bus.m_arvalid !== 1'b0) begin bad++; $display("FAIL reset_arvalid got=%b exp=0", axi_bus.m_arvalid); end
    total++; if (axi_bus.m_rready !== 1'b0) begin bad++; $display("FAIL reset_rready got=%b exp=0", axi_bus.m_rready); end
    total++; if ({axi_bus.m_awvalid, axi_bus.m_wvalid, axi_bus.m_bready} !== 3'b001) begin
      bad++; $display("FAIL reset_write_idle got=%b exp=001", {axi_bus.m_awvalid, axi_bus.m_wvalid, axi_bus.m_bready});
    end
  endtask

  task automatic test_single();
    bit to;
    clear_mon();
    issue_start(32'h0000_0101, 16'd3);
    wait_done(100, to);
    total++; if (to) begin bad++; $display("FAIL single_timeout got=timeout exp=done"); end
    total++; if (ar_addr_q.size() != 1) begin bad++; $display("FAIL single_ar_count got=%0d exp=1", ar_addr_q.size()); end
    total++; if (ar_addr_q[0] !== 32'h100) begin bad++; $display("FAIL single_aradr got=%h exp=00000100", ar_addr_q[0]); end
    total++; if (ar_len_q[0] !== 8'd2) begin bad++; $display("FAIL single_arlen got=%0d exp=2", ar_len_q[0]); end
    total++; if (word_q.size() != 3) begin bad++; $display("FAIL single_word_count got=%0d exp=3", word_q.size()); end
    for (int i = 0; i < 3; i++) begin
      total++; if (word_q[i] !== 32'h40 + 32'(i)) begin bad++; $display("FAIL single_word%0d got=%h exp=%h", i, word_q[i], 32'h40 + 32'(i)); end
    end
    total++; if (ar_cyc_q[0] != accept_q[0] + 1) begin bad++; $display("FAIL single_ar_latency got=%0d exp=%0d", ar_cyc_q[0], accept_q[0] + 1); end
    total++; if (done_q.size() != 1 || done_q[0] != last_beat_cyc + 1) begin
      bad++; $display("FAIL single_done_timing got=%0d exp=%0d", done_q[0], last_beat_cyc + 1);
    end
    total++; if (done_q[0] != accept_q[0] + 5) begin bad++; $display("FAIL single_total_latency got=%0d exp=%0d", done_q[0], accept_q[0] + 5); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_multi_burst();
    bit to;
    logic [31:0] ea[3] = '{32'h0, 32'h20, 32'h40};
    logic [7:0]  el[3] = '{8'd7, 8'd7, 8'd3};
    clear_mon();
    issue_start(32'h0, 16'd20);
    wait_done(200, to);
    total++; if (to) begin bad++; $display("FAIL multi_timeout got=timeout exp=done"); end
    total++; if (ar_addr_q.size() != 3) begin bad++; $display("FAIL multi_ar_count got=%0d exp=3", ar_addr_q.size()); end
    for (int i = 0; i < 3; i++) begin
      total++; if (ar_addr_q[i] !== ea[i] || ar_len_q[i] !== el[i]) begin
        bad++; $display("FAIL multi_ar%0d got=%h/%0d exp=%h/%0d", i, ar_addr_q[i], ar_len_q[i], ea[i], el[i]);
      end
    end
    total++; if (ar_cyc_q[1] - ar_cyc_q[0] != 9 || ar_cyc_q[2] - ar_cyc_q[1] != 9) begin
      bad++; $display("FAIL multi_ar_spacing got=%0d,%0d exp=9,9", ar_cyc_q[1] - ar_cyc_q[0], ar_cyc_q[2] - ar_cyc_q[1]);
    end
    total++; if (word_q.size() != 20) begin bad++; $display("FAIL multi_word_count got=%0d exp=20", word_q.size()); end
    for (int i = 0; i < 20; i++) begin
      total++; if (word_q[i] !== 32'(i)) begin bad++; $display("FAIL multi_word%0d got=%h exp=%h", i, word_q[i], 32'(i)); end
    end
  endtask

  task automatic test_page_cross();
    bit to;
    clear_mon();
    issue_start(32'h0000_0FF8, 16'd8);
    wait_done(200, to);
    total++; if (to) begin bad++; $display("FAIL page_timeout got=timeout exp=done"); end
    total++; if (ar_addr_q.size() != 2) begin bad++; $display("FAIL page_ar_count got=%0d exp=2", ar_addr_q.size()); end
    total++; if (ar_addr_q[0] !== 32'hFF8 || ar_len_q[0] !== 8'd1) begin
      bad++; $display("FAIL page_ar0 got=%h/%0d exp=00000ff8/1", ar_addr_q[0], ar_len_q[0]);
    end
    total++; if (ar_addr_q[1] !== 32'h1000 || ar_len_q[1] !== 8'd5) begin
      bad++; $display("FAIL page_ar1 got=%h/%0d exp=00001000/5", ar_addr_q[1], ar_len_q[1]);
    end
    total++; if (word_q.size() != 8) begin bad++; $display("FAIL page_word_count got=%0d exp=8", word_q.size()); end
    for (int i = 0; i < 8; i++) begin
      total++; if (word_q[i] !== 32'h3FE + 32'(i)) begin bad++; $display("FAIL page_word%0d got=%h exp=%h", i, word_q[i], 32'h3FE + 32'(i)); end
    end
  endtask

  task automatic test_backpressure();
    bit to;
    clear_mon();
    stall_cfg = 5; stall_gen++;
    rand_ready = 1'b1;
    issue_start(32'h0000_0300, 16'd12);
    wait_done(600, to);
    rand_ready = 1'b0;
    total++; if (to) begin bad++; $display("FAIL bp_timeout got=timeout exp=done"); end
    total++; if (ar_wait != 5) begin bad++; $display("FAIL bp_ar_wait got=%0d exp=5", ar_wait); end
    total++; if (ar_viol != 0) begin bad++; $display("FAIL bp_ar_stable got=%0d exp=0", ar_viol); end
    total++; if (rr_viol != 0) begin bad++; $display("FAIL bp_rready_follow got=%0d exp=0", rr_viol); end
    total++; if (ar_addr_q.size() != 2 || ar_addr_q[0] !== 32'h300 || ar_len_q[0] !== 8'd7 ||
                 ar_addr_q[1] !== 32'h320 || ar_len_q[1] !== 8'd3) begin
      bad++; $display("FAIL bp_ars got=%0d:%h/%0d exp=2:00000300/7", ar_addr_q.size(), ar_addr_q[0], ar_len_q[0]);
    end
    total++; if (word_q.size() != 12) begin bad++; $display("FAIL bp_word_count got=%0d exp=12", word_q.size()); end
    for (int i = 0; i < 12; i++) begin
      total++; if (word_q[i] !== 32'hC0 + 32'(i)) begin bad++; $display("FAIL bp_word%0d got=%h exp=%h", i, word_q[i], 32'hC0 + 32'(i)); end
    end
  endtask

  task automatic test_zero_count();
    bit to;
    clear_mon();
    issue_start(32'h0000_0400, 16'd0);
    wait_done(20, to);
    total++; if (to) begin bad++; $display("FAIL zero_timeout got=timeout exp=done"); end
    total++; if (done_q.size() != 1 || done_q[0] != accept_q[0] + 1) begin
      bad++; $display("FAIL zero_done_timing got=%0d exp=%0d", done_q[0], accept_q[0] + 1);
    end
    total++; if (ar_addr_q.size() != 0) begin bad++; $display("FAIL zero_no_ar got=%0d exp=0", ar_addr_q.size()); end
    total++; if (word_q.size() != 0) begin bad++; $display("FAIL zero_no_words got=%0d exp=0", word_q.size()); end
  endtask

  task automatic test_ignored_start();
    bit to;
    clear_mon();
    issue_start(32'h0000_0040, 16'd10);
    repeat (4) begin @(posedge clk); #1; end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL ign_busy got=%b exp=1", busy); end
    issue_start(32'h0000_0800, 16'd5);
    wait_done(200, to);
    total++; if (to) begin bad++; $display("FAIL ign_timeout got=timeout exp=done"); end
    total++; if (accept_q.size() != 1) begin bad++; $display("FAIL ign_accepts got=%0d exp=1", accept_q.size()); end
    total++; if (ar_addr_q.size() != 2 || ar_addr_q[0] !== 32'h40 || ar_len_q[0] !== 8'd7 ||
                 ar_addr_q[1] !== 32'h60 || ar_len_q[1] !== 8'd1) begin
      bad++; $display("FAIL ign_ars got=%0d:%h/%0d exp=2:00000040/7", ar_addr_q.size(), ar_addr_q[0], ar_len_q[0]);
    end
    total++; if (word_q.size() != 10) begin bad++; $display("FAIL ign_word_count got=%0d exp=10", word_q.size()); end
    for (int i = 0; i < 10; i++) begin
      total++; if (word_q[i] !== 32'h10 + 32'(i)) begin bad++; $display("FAIL ign_word%0d got=%h exp=%h", i, word_q[i], 32'h10 + 32'(i)); end
    end
    total++; if (done_q.size() != 1) begin bad++; $display("FAIL ign_done_count got=%0d exp=1", done_q.size()); end
  endtask

  task automatic test_back_to_back();
    bit to1, to2;
    logic [31:0] exp_w[5] = '{32'h140, 32'h141, 32'h180, 32'h181, 32'h182};
    clear_mon();
    issue_start(32'h0000_0500, 16'd2);
    wait_done(100, to1);
    issue_start(32'h0000_0600, 16'd3);
    wait_done(100, to2);
    total++; if (to1 || to2) begin bad++; $display("FAIL b2b_timeout got=%b%b exp=00", to1, to2); end
    total++; if (accept_q.size() != 2 || accept_q[1] != done_q[0] + 1) begin
      bad++; $display("FAIL b2b_accept got=%0d exp=%0d", accept_q[1], done_q[0] + 1);
    end
    total++; if (word_q.size() != 5) begin bad++; $display("FAIL b2b_word_count got=%0d exp=5", word_q.size()); end
    for (int i = 0; i < 5; i++) begin
      total++; if (word_q[i] !== exp_w[i]) begin bad++; $display("FAIL b2b_word%0d got=%h exp=%h", i, word_q[i], exp_w[i]); end
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    int n;
    clear_mon();
    issue_start(32'h0, 16'd8);
    n = 0; to = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) n++;
      if (n == 3) begin to = 1'b0; break; end
    end
    @(posedge clk); #1;
    total++; if (to) begin bad++; $display("FAIL rmid_wait got=timeout exp=3beats"); end
    total++; if (out_valid !== 1'b1 || out_data !== 32'd3) begin
      bad++; $display("FAIL rmid_fourth_beat got=%b/%h exp=1/00000003", out_valid, out_data);
    end
    reset = 1'b1;
    #1;
    total++; if (axi_bus.m_arvalid !== 1'b0) begin bad++; $display("FAIL rmid_arvalid got=%b exp=0", axi_bus.m_arvalid); end
    total++; if (axi_bus.m_rready !== 1'b0) begin bad++; $display("FAIL rmid_rready got=%b exp=0", axi_bus.m_rready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_out_valid got=%b exp=0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rmid_done got=%b exp=0", done); end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    clear_mon();
    issue_start(32'h0000_0200, 16'd4);
    wait_done(100, to);
    total++; if (to) begin bad++; $display("FAIL rmid_fresh_timeout got=timeout exp=done"); end
    total++; if (word_q.size() != 4) begin bad++; $display("FAIL rmid_fresh_count got=%0d exp=4", word_q.size()); end
    for (int i = 0; i < 4; i++) begin
      total++; if (word_q[i] !== 32'h80 + 32'(i)) begin bad++; $display("FAIL rmid_fresh_word%0d got=%h exp=%h", i, word_q[i], 32'h80 + 32'(i)); end
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    start_addr = '0;
    word_count = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    test_single();
    test_multi_burst();
    test_page_cross();
    test_backpressure();
    test_zero_count();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
